uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver. Companion to the existing uart_tx on the same serial link.
- Samples the asynchronous rx line mid-bit using a BIT_PERIOD clock counter and assembles each byte LSB first.
- Presents each byte with a one-cycle valid strobe, plus a frame-end pulse (rx_done) that drives uart_tx's rx_done input.
- Mirrors the last good byte onto board LEDs.

Parameters:
- BAUD_RATE, 9600, serial bit rate.
- CLOCK_FREQ, 100_000_000, clk frequency in Hz.
- BIT_PERIOD (localparam), CLOCK_FREQ/BAUD_RATE, clocks per bit. Integer divide, truncated.
- HALF_PERIOD (localparam), BIT_PERIOD/2, clocks from start edge to start-bit centre.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- rx  in  1  asynchronous serial input; idles high.
- rx_data  out  8  last correctly framed byte. Reset 8'h00.
- rx_valid  out  1  one-cycle pulse when rx_data updates. Reset 0.
- rx_done  out  1  one-cycle pulse at the end of every frame, good or bad. Reset 0.
- frame_err  out  1  one-cycle pulse when the stop bit samples 0. Reset 0.
- rx_busy  out  1  high in any state other than IDLE. Reset 0.
- LED  out  8  equals rx_data.

Behaviour:
- Input synchroniser:
  - rx passes through a 2-FF synchroniser; both FFs reset to 1. The result is rx_s.
  - A third register rx_d holds the previous rx_s.
  - Start edge = rx_d==1 && rx_s==0.
- State machine: IDLE, START, DATA, STOP (2-bit encoding, shared constants). clk_count is 16 bits; bit_index is 3 bits.
- IDLE:
  - clk_count=0, bit_index=0.
  - On a start edge, go to START.
  - A line held low (break, or after a frame error) never retriggers. A fresh 1->0 edge is required.
- START:
  - Count to HALF_PERIOD-1, then sample rx_s.
  - rx_s==0: clear clk_count and go to DATA.
  - rx_s==1: glitch. Return to IDLE silently with no pulses.
- DATA:
  - Count to BIT_PERIOD-1, then sample rx_s into shift_reg MSB and shift right. LSB arrives first.
  - Increment bit_index and clear clk_count.
  - After the 8th sample (bit_index==7 at sample time), go to STOP.
- STOP:
  - Count to BIT_PERIOD-1, then sample rx_s and go to IDLE.
  - rx_s==1: next cycle rx_data<=shift_reg, rx_valid=1, rx_done=1.
  - rx_s==0: frame_err=1, rx_done=1. rx_data is unchanged.
- Latency: rx_valid rises 2 (sync) + 1 (edge) + HALF_PERIOD + 9*BIT_PERIOD clocks ±1 after the rx falling edge.
- Pulses: rx_valid, rx_done and frame_err are never high for more than one cycle. rx_valid and frame_err are mutually exclusive.
- Back-to-back frames: the receiver returns to IDLE at stop-bit centre, so the next start edge half a bit later is caught. No frame is lost at nominal baud.
- Reset mid-frame: next cycle the state is IDLE, all outputs are at reset values, and the synchroniser is preset to 1. A frame in progress is discarded with no pulses.
- No flow control: the consumer must take rx_data within one frame time. rx_data is overwritten by the next good frame.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each sample point takes 3 samples at counts C-1, C and C+1, where C = HALF_PERIOD-1 in START and BIT_PERIOD-1 otherwise.
  - The bit value is the 2-of-3 majority.
  - The state transition occurs one cycle later (at C+1). The counter restarts from 1 so bit spacing is preserved.
- Undefined: single sample at C, as described in Behaviour.

Decomposition:
- Package uart_pkg:
  - State encodings IDLE/START/DATA/STOP (shared with uart_tx).
  - DATA_BITS=8.
  - A function computing BIT_PERIOD from CLOCK_FREQ and BAUD_RATE.
- Sub-module uart_rx_sync: 2-FF synchroniser plus edge detect. Outputs rx_s and start_edge. Reused by any future serial input.

Test Plan (CLOCK_FREQ=1_000_000, BAUD_RATE=62_500, so BIT_PERIOD=16 and HALF_PERIOD=8):
- Single byte 8'hA5, 8N1 -> rx_data=8'hA5, exactly one rx_valid and one rx_done, LED=8'hA5, frame_err never high.
- Back-to-back bytes 8'h00 then 8'hFF, 0 idle clocks between stop and start -> two rx_valid pulses, rx_data=8'h00 then 8'hFF.
- Stop bit driven 0 for byte 8'h3C -> frame_err and rx_done pulse once, no rx_valid, rx_data holds its prior value. The line then stays low 40 clocks -> no new frame until rx returns high and falls again.
- 4-clock low glitch on rx -> returns to IDLE, no pulses, rx_busy high for 8-9 clocks only.
- reset=0 for 1 cycle at DATA bit 4 of byte 8'h55 -> next cycle all outputs at reset values. A following 8'h81 is received correctly.
- With UART_RX_MAJORITY_EN: byte 8'hC3 with a 1-clock inverted spike exactly at each sample centre -> rx_data=8'hC3. Without the macro -> mismatch is expected, confirming the macro switches the sampling.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame width and bit-period helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;

  function automatic int calc_bit_period(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bundle from uart_rx to its consumer.
interface uart_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  modport master (output rx_data, rx_valid, rx_done, frame_err, rx_busy);
  modport slave  (input  rx_data, rx_valid, rx_done, frame_err, rx_busy);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line plus falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic start_edge
);

  logic rx_meta;
  logic rx_d;

  // All stages preset high so a reset never fabricates a start edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign start_edge = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; define UART_RX_MAJORITY_EN for
// 2-of-3 majority sampling around each bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  uart_rx_if.master  rx_bus,
  output logic [7:0] LED
);

  localparam int BIT_PERIOD  = calc_bit_period(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);

  uart_state_t state, state_next;
  logic [15:0] clk_count, count_next;
  logic [2:0]  bit_index, index_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_q, data_next;
  logic        valid_q, valid_next;
  logic        done_q, done_next;
  logic        ferr_q, ferr_next;

  logic        rx_s;
  logic        start_edge;
  logic [15:0] sample_point;
  logic [15:0] count_restart;
  logic        sample_tick;
  logic        bit_val;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_s       (rx_s),
    .start_edge (start_edge)
  );

  assign sample_point = (state == START) ? HALF_LAST : BIT_LAST;

`ifdef UART_RX_MAJORITY_EN
  logic maj_a;
  logic maj_b;

  // Early and centre samples; the late one is rx_s itself on the decision cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
    end else begin
      if (clk_count == sample_point - 16'd1) maj_a <= rx_s;
      if (clk_count == sample_point)         maj_b <= rx_s;
    end
  end

  assign sample_tick   = (clk_count == sample_point + 16'd1);
  assign bit_val       = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
  assign count_restart = 16'd1;
`else
  assign sample_tick   = (clk_count == sample_point);
  assign bit_val       = rx_s;
  assign count_restart = 16'd0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      clk_count <= 16'd0;
      bit_index <= 3'd0;
      shift_reg <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state     <= state_next;
      clk_count <= count_next;
      bit_index <= index_next;
      shift_reg <= shift_next;
      data_q    <= data_next;
      valid_q   <= valid_next;
      done_q    <= done_next;
      ferr_q    <= ferr_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = clk_count;
    index_next = bit_index;
    shift_next = shift_reg;
    data_next  = data_q;
    valid_next = 1'b0;
    done_next  = 1'b0;
    ferr_next  = 1'b0;

    case (state)
      IDLE: begin
        count_next = 16'd0;
        index_next = 3'd0;
        if (start_edge) state_next = START;
      end

      // A start bit that has gone high again by its centre was a glitch.
      START: begin
        if (sample_tick) begin
          if (bit_val) begin
            state_next = IDLE;
            count_next = 16'd0;
          end else begin
            state_next = DATA;
            count_next = count_restart;
          end
        end else begin
          count_next = clk_count + 16'd1;
        end
      end

      DATA: begin
        if (sample_tick) begin
          shift_next = {bit_val, shift_reg[7:1]};
          index_next = bit_index + 3'd1;
          count_next = count_restart;
          if (bit_index == 3'(DATA_BITS - 1)) state_next = STOP;
        end else begin
          count_next = clk_count + 16'd1;
        end
      end

      STOP: begin
        if (sample_tick) begin
          state_next = IDLE;
          count_next = 16'd0;
          done_next  = 1'b1;
          if (bit_val) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            ferr_next  = 1'b1;
          end
        end else begin
          count_next = clk_count + 16'd1;
        end
      end
    endcase
  end

  assign rx_bus.rx_data   = data_q;
  assign rx_bus.rx_valid  = valid_q;
  assign rx_bus.rx_done   = done_q;
  assign rx_bus.frame_err = ferr_q;
  assign rx_bus.rx_busy   = (state != IDLE);
  assign LED              = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int BIT     = 16;
  localparam int HALF    = 8;
  localparam int EXP_LAT = 2 + 1 + HALF + 9 * BIT;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] LED;

  uart_rx_if bus ();

  uart_rx #(
    .BAUD_RATE  (62_500),
    .CLOCK_FREQ (1_000_000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .rx_bus (bus),
    .LED    (LED)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int check_cnt = 0;
  int pass_cnt  = 0;

  int valid_cnt, done_cnt, ferr_cnt, busy_cnt;
  int viol_cnt = 0;
  int valid_cyc, fall_cyc;
  logic [7:0] got_q[$];
  logic prev_valid = 1'b0, prev_done = 1'b0, prev_ferr = 1'b0;
  logic [7:0] last_good;

  // Monitor samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      got_q.push_back(bus.rx_data);
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (bus.rx_done)   done_cnt++;
    if (bus.frame_err) ferr_cnt++;
    if (bus.rx_busy)   busy_cnt++;
    if ((bus.rx_valid && prev_valid) || (bus.rx_done && prev_done) ||
        (bus.frame_err && prev_ferr) || (bus.rx_valid && bus.frame_err))
      viol_cnt++;
    prev_valid = bus.rx_valid;
    prev_done  = bus.rx_done;
    prev_ferr  = bus.frame_err;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_cnt++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    else
      pass_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_monitor();
    valid_cnt = 0;
    done_cnt  = 0;
    ferr_cnt  = 0;
    busy_cnt  = 0;
    got_q.delete();
  endtask

  // Reference: what the receiver should deliver for one frame. A spike inverts
  // the line for one clock at each data-bit centre.
  function automatic logic [8:0] model_frame(input logic [7:0] data,
                                             input logic stop_bit, input logic spike);
    logic [7:0] seen;
    int ones;
    for (int k = 0; k < 8; k++) begin
      ones = spike ? (data[k] ? 2 : 1) : (data[k] ? 3 : 0);
`ifdef UART_RX_MAJORITY_EN
      seen[k] = (ones >= 2);
`else
      seen[k] = spike ? ~data[k] : data[k];
`endif
    end
    return {stop_bit, seen};
  endfunction

  // Drives one 160-clock frame; optionally pulses reset low at clock abort_cycle.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit,
                                input logic spike, input int abort_cycle);
    logic [9:0] frame;
    logic v;
    frame = {stop_bit, data, 1'b0};
    for (int j = 0; j < 10 * BIT; j++) begin
      v = frame[j / BIT];
      if (spike && j >= BIT && j < 9 * BIT && (j % BIT) == HALF) v = ~v;
      rx = v;
      if (j == 0) fall_cyc = cyc;
      if (j == abort_cycle) begin
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        rx    = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input logic [7:0] data, input logic stop_bit,
                           input logic spike, input string name);
    logic [8:0] exp;
    int lat;
    exp = model_frame(data, stop_bit, spike);
    clear_monitor();
    apply_stimulus(data, stop_bit, spike, -1);
    idle(8);
    if (exp[8]) last_good = exp[7:0];
    check_output({name, "_valid"}, valid_cnt, {31'd0, exp[8]});
    check_output({name, "_ferr"}, ferr_cnt, {31'd0, ~exp[8]});
    check_output({name, "_done"}, done_cnt, 1);
    check_output({name, "_data"}, bus.rx_data, last_good);
    check_output({name, "_led"}, LED, last_good);
    if (exp[8]) begin
      lat = valid_cyc - fall_cyc;
      check_output({name, "_latency_ok"}, (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [7:0] rbyte;

  initial begin
    rx        = 1'b1;
    reset     = 1'b0;
    last_good = 8'h00;
    clear_monitor();
    idle(3);
    check_output("reset_data", bus.rx_data, 8'h00);
    check_output("reset_valid", bus.rx_valid, 0);
    check_output("reset_done", bus.rx_done, 0);
    check_output("reset_ferr", bus.frame_err, 0);
    check_output("reset_busy", bus.rx_busy, 0);
    check_output("reset_led", LED, 8'h00);
    reset = 1'b1;
    idle(5);

    run_frame(8'hA5, 1'b1, 1'b0, "a5");

    for (int i = 0; i < 4; i++) begin
      rbyte = 8'($urandom);
      run_frame(rbyte, 1'b1, 1'b0, "rand");
      idle($urandom_range(0, 5));
    end

    // Back-to-back frames with no idle time between stop and start.
    clear_monitor();
    apply_stimulus(8'h00, 1'b1, 1'b0, -1);
    apply_stimulus(8'hFF, 1'b1, 1'b0, -1);
    idle(8);
    last_good = 8'hFF;
    check_output("b2b_count", valid_cnt, 2);
    check_output("b2b_first", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h00);
    check_output("b2b_second", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'hFF);
    check_output("b2b_ferr", ferr_cnt, 0);

    // Bad stop bit, then a held-low line that must not retrigger.
    run_frame(8'h3C, 1'b0, 1'b0, "ferr");
    clear_monitor();
    idle(40);
    check_output("low_hold_busy", busy_cnt, 0);
    check_output("low_hold_done", done_cnt, 0);
    rx = 1'b1;
    idle(20);

    clear_monitor();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    check_output("glitch_busy_ok", (busy_cnt >= 8 && busy_cnt <= 9), 1);
    check_output("glitch_done", done_cnt, 0);
    check_output("glitch_valid", valid_cnt, 0);
    check_output("glitch_ferr", ferr_cnt, 0);

    // Reset pulse in the middle of data bit 4.
    clear_monitor();
    apply_stimulus(8'h55, 1'b1, 1'b0, 5 * BIT + HALF);
    last_good = 8'h00;
    check_output("midrst_data", bus.rx_data, 8'h00);
    check_output("midrst_valid", bus.rx_valid, 0);
    check_output("midrst_done", bus.rx_done, 0);
    check_output("midrst_ferr", bus.frame_err, 0);
    check_output("midrst_busy", bus.rx_busy, 0);
    check_output("midrst_led", LED, 8'h00);
    idle(20);
    check_output("midrst_no_pulse", valid_cnt + done_cnt + ferr_cnt, 0);
    run_frame(8'h81, 1'b1, 1'b0, "after_rst");

    run_frame(8'hC3, 1'b1, 1'b1, "spike");

    check_output("pulse_rules", viol_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
